// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point add/subtract unit.
// - Default IEEE single-precision field widths and the constants derived from them.
// - Result flag bit positions inside the 4-bit flag vector.
// - Special-operand summary carried from unpack down to pack.
// - Canonical quiet-NaN builder for any exponent/mantissa split.
package fp_pkg;

  localparam int unsigned DEF_EXP_W = 8;
  localparam int unsigned DEF_MAN_W = 23;
  localparam int unsigned W         = 1 + DEF_EXP_W + DEF_MAN_W;
  localparam int unsigned EXP_MAX   = (1 << DEF_EXP_W) - 1;
  localparam int unsigned BIAS      = (1 << (DEF_EXP_W - 1)) - 1;

  // Flag vector layout: {invalid, overflow, underflow, inexact}
  localparam int unsigned FLG_INV = 3;
  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_UNF = 1;
  localparam int unsigned FLG_INX = 0;

  // Special-case decision made at unpack time; overrides the datapath at pack time.
  typedef struct packed {
    logic nan;   // result is canonical qNaN, invalid raised
    logic inf;   // result is infinity with sign below
    logic sign;  // sign of the infinity operand
  } fp_special_t;

  // Canonical qNaN: sign 0, exponent all ones, mantissa MSB set, rest zero.
  // Returned right-aligned in 64 bits; callers truncate to their word width.
  function automatic logic [63:0] qnan_bits(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] exp_ones;
    exp_ones  = (64'd1 << exp_w) - 64'd1;
    qnan_bits = (exp_ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
// Ports:
//   in_i  [WIDTH-1:0]  value to scan from the MSB
//   cnt_o [CNT_W-1:0]  number of zeros above the highest set bit (WIDTH when in_i == 0)
module fp_lzc #(
  parameter int unsigned  WIDTH = 28,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    cnt_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) begin
        cnt_o = CNT_W'(WIDTH - 1 - unsigned'(i));
      end
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined IEEE-754 add/subtract with round-to-nearest-even.
//   S1 unpack, special detect, magnitude swap, align with sticky
//   S2 magnitude add/subtract, leading-zero count
//   S3 normalise, round, pack, flags (registered outputs)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid_i / in_ready_o    operand handshake
//   in_op_i                    0: a+b, 1: a-b
//   in_a_i, in_b_i             operands
//   out_valid_o / out_ready_i  result handshake
//   out_res_o                  rounded result
//   out_flags_o                {invalid, overflow, underflow, inexact}
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int unsigned  EXP_W  = DEF_EXP_W,
  parameter int unsigned  MAN_W  = DEF_MAN_W,
  localparam int unsigned WORD_W = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_op_i,
  input  logic [WORD_W-1:0] in_a_i,
  input  logic [WORD_W-1:0] in_b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_res_o,
  output logic [3:0]        out_flags_o
);

  localparam int unsigned DW  = MAN_W + 5;            // {carry, hidden, man, G, R, S}
  localparam int unsigned NW  = MAN_W + 4;            // {hidden, man, G, R, S}
  localparam int unsigned AW  = MAN_W + 3;            // {hidden, man, G, R}
  localparam int unsigned SAT = MAN_W + 3;            // alignment shift saturation
  localparam int unsigned SHW = $clog2(SAT + 1);
  localparam int unsigned LZW = $clog2(DW + 1);
  localparam int unsigned EW  = EXP_W + 1;            // room for rounding carry
  localparam int unsigned SW  = (EW > LZW) ? EW : LZW;

  localparam logic [EXP_W-1:0]  EXP_ONES = '1;
  localparam logic [WORD_W-1:0] QNAN     = WORD_W'(qnan_bits(EXP_W, MAN_W));

  logic adv;
  logic out_valid_q;

  assign adv        = ~out_valid_q | out_ready_i;
  assign in_ready_o = adv;

  // ---------------------------------------------------------------- S1
  logic             a_s, b_s, a_h, b_h;
  logic [EXP_W-1:0] a_e, b_e, a_ee, b_ee;
  logic [MAN_W-1:0] a_m, b_m;
  logic             a_nan, b_nan, a_inf, b_inf, swap;

  assign a_s   = in_a_i[WORD_W-1];
  assign a_e   = in_a_i[WORD_W-2 -: EXP_W];
  assign a_m   = in_a_i[MAN_W-1:0];
  assign b_s   = in_b_i[WORD_W-1] ^ in_op_i;
  assign b_e   = in_b_i[WORD_W-2 -: EXP_W];
  assign b_m   = in_b_i[MAN_W-1:0];
  assign a_h   = |a_e;
  assign b_h   = |b_e;
  // Subnormals share the scale of exponent 1.
  assign a_ee  = a_h ? a_e : EXP_W'(1);
  assign b_ee  = b_h ? b_e : EXP_W'(1);
  assign a_nan = (&a_e) & (|a_m);
  assign b_nan = (&b_e) & (|b_m);
  assign a_inf = (&a_e) & ~(|a_m);
  assign b_inf = (&b_e) & ~(|b_m);
  assign swap  = {b_ee, b_h, b_m} > {a_ee, a_h, a_m};

  logic             x_s, x_h, y_h;
  logic [EXP_W-1:0] x_e, y_e, e_diff;
  logic [MAN_W-1:0] x_m, y_m;
  logic [SHW-1:0]   d_sat;
  logic [2*AW-1:0]  y_sh;
  logic [DW-1:0]    x_al, y_al;
  fp_special_t      spc_d;

  always_comb begin
    x_s    = swap ? b_s  : a_s;
    x_e    = swap ? b_ee : a_ee;
    x_h    = swap ? b_h  : a_h;
    x_m    = swap ? b_m  : a_m;
    y_e    = swap ? a_ee : b_ee;
    y_h    = swap ? a_h  : b_h;
    y_m    = swap ? a_m  : b_m;
    e_diff = x_e - y_e;
    d_sat  = (32'(e_diff) > SAT) ? SHW'(SAT) : SHW'(e_diff);
    // Lower half catches everything shifted past R; it collapses into sticky.
    y_sh   = {y_h, y_m, 2'b00, {AW{1'b0}}} >> d_sat;
    x_al   = {1'b0, x_h, x_m, 3'b000};
    y_al   = {1'b0, y_sh[2*AW-1:AW], |y_sh[AW-1:0]};

    spc_d.nan  = a_nan | b_nan | (a_inf & b_inf & (a_s ^ b_s));
    spc_d.inf  = (a_inf | b_inf) & ~spc_d.nan;
    spc_d.sign = a_inf ? a_s : b_s;
  end

  logic             s1_valid_q, s1_sign_q, s1_sub_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [DW-1:0]    s1_x_q, s1_y_q;
  fp_special_t      s1_spc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_exp_q   <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_spc_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid_i;
      s1_sign_q  <= x_s;
      s1_sub_q   <= a_s ^ b_s;
      s1_exp_q   <= x_e;
      s1_x_q     <= x_al;
      s1_y_q     <= y_al;
      s1_spc_q   <= spc_d;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [DW-1:0]  sum_d;
  logic [LZW-1:0] lzc_d;

  // X >= Y in magnitude, so the difference never goes negative.
  assign sum_d = s1_sub_q ? (s1_x_q - s1_y_q) : (s1_x_q + s1_y_q);

  fp_lzc #(
    .WIDTH (DW)
  ) u_lzc (
    .in_i  (sum_d),
    .cnt_o (lzc_d)
  );

  logic             s2_valid_q, s2_sign_q, s2_sub_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [DW-1:0]    s2_sum_q;
  logic [LZW-1:0]   s2_lzc_q;
  fp_special_t      s2_spc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_sub_q   <= 1'b0;
      s2_exp_q   <= '0;
      s2_sum_q   <= '0;
      s2_lzc_q   <= '0;
      s2_spc_q   <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_sub_q   <= s1_sub_q;
      s2_exp_q   <= s1_exp_q;
      s2_sum_q   <= sum_d;
      s2_lzc_q   <= lzc_d;
      s2_spc_q   <= s1_spc_q;
    end
  end

  // ---------------------------------------------------------------- S3
  logic [EW-1:0]      exp_n, exp_f;
  logic [NW-1:0]      norm;
  logic [SW-1:0]      lz, sh_lim, sh_amt;
  logic [MAN_W+1:0]   rounded;
  logic               rnd_inc, inexact, ovf, res_sign;
  logic [WORD_W-1:0]  res_d;
  logic [3:0]         flg_d;

  always_comb begin
    lz     = '0;
    sh_lim = '0;
    sh_amt = '0;
    if (s2_sum_q[DW-1]) begin
      norm  = {s2_sum_q[DW-1:2], |s2_sum_q[1:0]};
      exp_n = EW'(s2_exp_q) + EW'(1);
    end else begin
      // Stop at exponent 1 so the result stays subnormal instead of wrapping.
      lz     = SW'(s2_lzc_q) - SW'(1);
      sh_lim = SW'(s2_exp_q) - SW'(1);
      sh_amt = (lz < sh_lim) ? lz : sh_lim;
      norm   = s2_sum_q[NW-1:0] << sh_amt;
      exp_n  = EW'(s2_exp_q) - EW'(sh_amt);
    end

    rnd_inc = norm[2] & (norm[3] | norm[1] | norm[0]);
    rounded = {1'b0, norm[NW-1:3]} + {{(MAN_W + 1){1'b0}}, rnd_inc};
    // Hidden bit clear means the exponent field encodes as 0.
    exp_f   = rounded[MAN_W+1] ? (exp_n + EW'(1)) : (rounded[MAN_W] ? exp_n : '0);
    inexact = |norm[2:0];
    ovf     = ~s2_spc_q.nan & ~s2_spc_q.inf & (exp_f >= {1'b0, EXP_ONES});
    // Exact cancellation gives +0; same-sign zeros keep their sign.
    res_sign = (s2_sub_q & ~(|s2_sum_q)) ? 1'b0 : s2_sign_q;

    flg_d = '0;
    if (s2_spc_q.nan) begin
      res_d          = QNAN;
      flg_d[FLG_INV] = 1'b1;
    end else if (s2_spc_q.inf) begin
      res_d = {s2_spc_q.sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (ovf) begin
      res_d          = {res_sign, EXP_ONES, {MAN_W{1'b0}}};
      flg_d[FLG_OVF] = 1'b1;
      flg_d[FLG_INX] = 1'b1;
    end else begin
      res_d          = {res_sign, exp_f[EXP_W-1:0], rounded[MAN_W-1:0]};
      flg_d[FLG_UNF] = ~(|exp_f) & inexact;
      flg_d[FLG_INX] = inexact;
    end
  end

  logic [WORD_W-1:0] out_res_q;
  logic [3:0]        out_flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_flags_q <= '0;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_res_q   <= res_d;
        out_flags_q <= flg_d;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_res_o   = out_res_q;
  assign out_flags_o = out_flags_q;

endmodule
